// File: rtl/hazard_stall_sequencer_if.sv
// rtl/hazard_stall_sequencer_if.sv - hazard inputs and pipeline control outputs of the stall sequencer
interface hazard_stall_sequencer_if;
    logic        id_exe_mem_read;
    logic        id_exe_reg_write;
    logic [4:0]  id_exe_dest;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        exe_branch_taken;
    logic        md_start;
    logic        md_done;
    logic        pc_write;
    logic        if_id_write;
    logic        id_exe_bubble;
    logic        if_id_flush;
    logic        md_timeout;
    logic [15:0] stall_count;

    // Pipeline side: reports hazards, consumes the enables.
    modport master (
        output id_exe_mem_read, id_exe_reg_write, id_exe_dest, if_id_rs, if_id_rt,
        output exe_branch_taken, md_start, md_done,
        input  pc_write, if_id_write, id_exe_bubble, if_id_flush, md_timeout, stall_count
    );

    // Sequencer side.
    modport slave (
        input  id_exe_mem_read, id_exe_reg_write, id_exe_dest, if_id_rs, if_id_rt,
        input  exe_branch_taken, md_start, md_done,
        output pc_write, if_id_write, id_exe_bubble, if_id_flush, md_timeout, stall_count
    );
endinterface

// File: rtl/hazard_stall_sequencer.sv
// rtl/hazard_stall_sequencer.sv - prioritised stall/flush sequencer (optional stall counter: HAZARD_STALL_CNT_EN)
module hazard_stall_sequencer #(
    parameter int MD_TIMEOUT = 32,
    parameter int CNT_W      = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    hazard_stall_sequencer_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q;
    logic             timeout_set;
    logic             load_hazard;

    logic             pc_write_c;
    logic             if_id_write_c;
    logic             id_exe_bubble_c;
    logic             if_id_flush_c;

    // Load-use detection: a load in ID/EXE whose target feeds the IF/ID instruction; $0 never hazards.
    always_comb begin
        load_hazard = bus.id_exe_mem_read
                    & bus.id_exe_reg_write
                    & (bus.id_exe_dest != 5'd0)
                    & ((bus.if_id_rs == bus.id_exe_dest) | (bus.if_id_rt == bus.id_exe_dest));
    end

    // Next-state and control decode; reset forces the pipeline frozen with NOPs injected.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_set     = 1'b0;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        id_exe_bubble_c = 1'b0;
        if_id_flush_c   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.exe_branch_taken) begin
                    // Wrong-path instruction in IF/ID is discarded, so any load stall is moot.
                    if_id_flush_c   = 1'b1;
                    id_exe_bubble_c = 1'b1;
                end else if (bus.md_start) begin
                    pc_write_c      = 1'b0;
                    if_id_write_c   = 1'b0;
                    id_exe_bubble_c = 1'b1;
                    wait_cnt_d      = CNT_ONE;
                    state_d         = ST_MD_WAIT;
                end else if (load_hazard) begin
                    // One cycle suffices: the load moves on to EX/MEM and the hazard vanishes.
                    pc_write_c      = 1'b0;
                    if_id_write_c   = 1'b0;
                    id_exe_bubble_c = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (bus.md_done) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    // Give up on the unit rather than deadlock the pipeline.
                    timeout_set = 1'b1;
                    state_d     = ST_RUN;
                    wait_cnt_d  = '0;
                end else begin
                    pc_write_c      = 1'b0;
                    if_id_write_c   = 1'b0;
                    id_exe_bubble_c = 1'b1;
                    wait_cnt_d      = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!rst_n) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            id_exe_bubble_c = 1'b1;
            if_id_flush_c   = 1'b1;
        end
    end

    // State and mul/div wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (!pc_write_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = 16'h0000;
`endif

    assign bus.pc_write      = pc_write_c;
    assign bus.if_id_write   = if_id_write_c;
    assign bus.id_exe_bubble = id_exe_bubble_c;
    assign bus.if_id_flush   = if_id_flush_c;
    assign bus.md_timeout    = timeout_q;

endmodule

// File: tb/tb_hazard_stall_sequencer.sv
// tb/tb_hazard_stall_sequencer.sv - self-checking bench for hazard_stall_sequencer
module tb_hazard_stall_sequencer;

    localparam int MD_TIMEOUT = 32;

    logic clk;
    logic rst_n;

    hazard_stall_sequencer_if hif ();

    hazard_stall_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: "busy" means a mul/div op holds EXE; elapsed counts stall cycles spent on it.
    bit m_busy     = 0;
    int m_elapsed  = 0;
    bit m_timeout  = 0;
    int m_stalls   = 0;

    bit e_pc, e_ifid, e_bub, e_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_stall_count();
`ifdef HAZARD_STALL_CNT_EN
        return (m_stalls > 65535) ? 65535 : m_stalls;
`else
        return 0;
`endif
    endfunction

    task automatic set_inputs(input bit mr, input bit rw, input int dest, input int rs, input int rt,
                              input bit br, input bit ms, input bit md);
        hif.id_exe_mem_read  = mr;
        hif.id_exe_reg_write = rw;
        hif.id_exe_dest      = 5'(dest);
        hif.if_id_rs         = 5'(rs);
        hif.if_id_rt         = 5'(rt);
        hif.exe_branch_taken = br;
        hif.md_start         = ms;
        hif.md_done          = md;
    endtask

    task automatic idle();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_elapsed = 0;
        m_timeout = 0;
        m_stalls  = 0;
    endtask

    // Apply the hazard rules to the current inputs; returns the expected controls and advances the model.
    task automatic model_cycle(output bit pc, output bit ifid, output bit bub, output bit flush);
        bit lh;
        bit stall;
        lh = hif.id_exe_mem_read && hif.id_exe_reg_write && (hif.id_exe_dest != 0)
             && (hif.if_id_rs == hif.id_exe_dest || hif.if_id_rt == hif.id_exe_dest);
        stall = 0;
        flush = 0;
        if (!rst_n) begin
            pc = 0; ifid = 0; bub = 1; flush = 1;
            model_reset();
            return;
        end
        if (m_busy) begin
            if (hif.md_done) begin
                m_busy = 0;
            end else if (m_elapsed == MD_TIMEOUT) begin
                m_busy    = 0;
                m_timeout = 1;
            end else begin
                stall = 1;
                m_elapsed++;
            end
        end else if (hif.exe_branch_taken) begin
            flush = 1;
        end else if (hif.md_start) begin
            stall     = 1;
            m_busy    = 1;
            m_elapsed = 1;
        end else if (lh) begin
            stall = 1;
        end
        pc   = !stall;
        ifid = !stall;
        bub  = stall || flush;
        if (stall) m_stalls++;
    endtask

    // One clock: inputs already driven after a falling edge; check, advance model, cross the rising edge.
    task automatic step(input string tag, input bit do_check);
        bit pc, ifid, bub, flush;
        bit tmo_before;
        int cnt_before;
        #1;
        tmo_before = m_timeout;
        cnt_before = exp_stall_count();
        model_cycle(pc, ifid, bub, flush);
        if (do_check) begin
            check({tag, ".pc_write"},      32'(hif.pc_write),      32'(pc));
            check({tag, ".if_id_write"},   32'(hif.if_id_write),   32'(ifid));
            check({tag, ".id_exe_bubble"}, 32'(hif.id_exe_bubble), 32'(bub));
            check({tag, ".if_id_flush"},   32'(hif.if_id_flush),   32'(flush));
            check({tag, ".md_timeout"},    32'(hif.md_timeout),    rst_n ? 32'(tmo_before) : 32'd0);
            check({tag, ".stall_count"},   32'(hif.stall_count),   rst_n ? 32'(cnt_before) : 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step("reset0", 1);
        step("reset1", 1);
        rst_n = 1'b1;

        step("idle", 1);
        step("idle2", 1);

        // Load-use on rs, one cycle, then the hazard is gone.
        set_inputs(1, 1, 5, 5, 0, 0, 0, 0);
        step("load_rs", 1);
        idle();
        step("after_load", 1);
        // Load-use on rt.
        set_inputs(1, 1, 9, 3, 9, 0, 0, 0);
        step("load_rt", 1);
        idle();
        // $0 never stalls.
        set_inputs(1, 1, 0, 0, 0, 0, 0, 0);
        step("load_r0", 1);
        // Not a load: no stall.
        set_inputs(0, 1, 5, 5, 5, 0, 0, 0);
        step("alu_dep", 1);
        // Branch beats a load hazard.
        set_inputs(1, 1, 5, 5, 0, 1, 0, 0);
        step("branch_load", 1);
        idle();
        step("after_branch", 1);

        // md_done in RUN is ignored.
        set_inputs(0, 0, 0, 0, 0, 0, 0, 1);
        step("done_in_run", 1);

        // mul/div completing four cycles after start.
        set_inputs(1, 1, 5, 5, 0, 0, 1, 0);
        step("md_start", 1);
        for (int i = 0; i < 3; i++) begin
            set_inputs(1, 1, 4, 4, 4, 1, 1, 0);
            step("md_wait", 1);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0, 1);
        step("md_done", 1);
        idle();
        step("md_after", 1);

        // mul/div that never finishes: timeout.
        set_inputs(0, 0, 0, 0, 0, 0, 1, 0);
        step("md_to_start", 1);
        idle();
        for (int i = 0; i < MD_TIMEOUT + 3; i++) step("md_to", 1);

        // Randomised traffic with narrow register ranges so collisions are frequent.
        for (int i = 0; i < 2000; i++) begin
            set_inputs(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) == 0));
            step("rand", 1);
        end

        // Reset in the middle of a mul/div wait takes effect immediately.
        idle();
        step("pre_rst", 1);
        hif.md_start = 1'b1;
        step("rst_md_start", 1);
        idle();
        step("rst_md_wait", 1);
        step("rst_md_wait", 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.pc_write",      32'(hif.pc_write),      32'd0);
        check("async_rst.if_id_write",   32'(hif.if_id_write),   32'd0);
        check("async_rst.id_exe_bubble", 32'(hif.id_exe_bubble), 32'd1);
        check("async_rst.if_id_flush",   32'(hif.if_id_flush),   32'd1);
        check("async_rst.md_timeout",    32'(hif.md_timeout),    32'd0);
        check("async_rst.stall_count",   32'(hif.stall_count),   32'd0);
        model_reset();
        @(negedge clk);
        step("rst_hold", 1);
        rst_n = 1'b1;
        step("rst_release", 1);
        step("rst_release2", 1);

        // Continuous load hazard long enough to saturate the stall counter.
        set_inputs(1, 1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step("sat", (i < 3));
        idle();
        step("sat_end", 1);
        step("sat_end2", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
